// File: rtl/dma_burst_sequencer.sv
// Splits one copy command into MAX_BURST-capped, 4 KB-safe bursts and drives the Dma read/write engines.
// One burst per CALC/ISSUE/GUARD/WAIT pass (4 cycles minimum); the next burst waits until both engines report idle.
module dma_burst_sequencer #(
  parameter int DMA_DATA_WIDTH_SRC = 64,
  parameter int DMA_AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST          = 16,
  parameter int BEATS_WIDTH        = 16
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic                          cmd_start_i,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] cmd_src_addr_i,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] cmd_dst_addr_i,
  input  logic [BEATS_WIDTH-1:0]        cmd_beats_i,
  output logic                          cmd_busy_o,
  output logic                          cmd_done_o,
  output logic                          read_start_o,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] read_addr_o,
  output logic [7:0]                    read_len_o,
  output logic [2:0]                    read_size_o,
  input  logic                          read_busy_i,
  output logic                          write_start_o,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] write_addr_o,
  output logic [7:0]                    write_len_o,
  output logic [2:0]                    write_size_o,
  input  logic                          write_busy_i
);

  localparam int AW        = DMA_AXI_ADDR_WIDTH;
  localparam int SIZE_LOG2 = $clog2(DMA_DATA_WIDTH_SRC / 8);
  // Wide enough for both the beat count plus one and the 4096-byte page room.
  localparam int CW        = (BEATS_WIDTH + 1 > 14) ? BEATS_WIDTH + 1 : 14;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'((64'd1 << SIZE_LOG2) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          src_q, dst_q;
  logic [BEATS_WIDTH-1:0] rem_q;
  logic [CW-1:0]          burst_q;
  logic [CW-1:0]          src_room, dst_room, burst_calc;
  logic [AW-1:0]          step;
  logic                   engines_idle;

  assign read_size_o  = 3'(SIZE_LOG2);
  assign write_size_o = 3'(SIZE_LOG2);
  assign engines_idle = !read_busy_i && !write_busy_i;
  assign step         = AW'(burst_q) << SIZE_LOG2;

  always_comb begin
    src_room   = (CW'(4096) - CW'(src_q[11:0])) >> SIZE_LOG2;
    dst_room   = (CW'(4096) - CW'(dst_q[11:0])) >> SIZE_LOG2;
    burst_calc = CW'(rem_q);
    if (CW'(MAX_BURST) < burst_calc) burst_calc = CW'(MAX_BURST);
    if (src_room < burst_calc)       burst_calc = src_room;
    if (dst_room < burst_calc)       burst_calc = dst_room;
  end

  always_comb begin
    state_d       = state_q;
    read_start_o  = 1'b0;
    write_start_o = 1'b0;
    cmd_busy_o    = 1'b0;
    cmd_done_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) state_d = (cmd_beats_i == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        cmd_busy_o = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_busy_o    = 1'b1;
        read_start_o  = 1'b1;
        write_start_o = 1'b1;
        state_d       = S_GUARD;
      end
      // Engines raise busy one cycle after start, so busy is not trusted here.
      S_GUARD: begin
        cmd_busy_o = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cmd_busy_o = 1'b1;
        if (engines_idle) state_d = (rem_q == BEATS_WIDTH'(burst_q)) ? S_DONE : S_CALC;
      end
      S_DONE: begin
        cmd_done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      burst_q      <= '0;
      read_addr_o  <= '0;
      write_addr_o <= '0;
      read_len_o   <= '0;
      write_len_o  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            src_q <= cmd_src_addr_i & ALIGN_MASK;
            dst_q <= cmd_dst_addr_i & ALIGN_MASK;
            rem_q <= cmd_beats_i;
          end
        end
        S_CALC: begin
          burst_q      <= burst_calc;
          read_addr_o  <= src_q;
          write_addr_o <= dst_q;
          read_len_o   <= 8'(burst_calc - CW'(1));
          write_len_o  <= 8'(burst_calc - CW'(1));
        end
        S_WAIT: begin
          if (engines_idle) begin
            src_q <= src_q + step;
            dst_q <= dst_q + step;
            rem_q <= rem_q - BEATS_WIDTH'(burst_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Randomized bench for dma_burst_sequencer: a burst-list model plus an emulated Dma with variable busy time.
module tb_dma_burst_sequencer;

  localparam int AW   = 32;
  localparam int BW   = 16;
  localparam int MAXB = 16;
  localparam int BPB  = 8;

  logic          m_axi_aclk = 1'b0;
  logic          m_axi_aresetn;
  logic          cmd_start_i;
  logic [AW-1:0] cmd_src_addr_i, cmd_dst_addr_i;
  logic [BW-1:0] cmd_beats_i;
  logic          cmd_busy_o, cmd_done_o;
  logic          read_start_o, write_start_o;
  logic [AW-1:0] read_addr_o, write_addr_o;
  logic [7:0]    read_len_o, write_len_o;
  logic [2:0]    read_size_o, write_size_o;
  logic          read_busy_i = 1'b0;
  logic          write_busy_i = 1'b0;

  always #5 m_axi_aclk = ~m_axi_aclk;

  dma_burst_sequencer #(
    .DMA_DATA_WIDTH_SRC(64),
    .DMA_AXI_ADDR_WIDTH(AW),
    .MAX_BURST(MAXB),
    .BEATS_WIDTH(BW)
  ) dut (
    .m_axi_aclk(m_axi_aclk),
    .m_axi_aresetn(m_axi_aresetn),
    .cmd_start_i(cmd_start_i),
    .cmd_src_addr_i(cmd_src_addr_i),
    .cmd_dst_addr_i(cmd_dst_addr_i),
    .cmd_beats_i(cmd_beats_i),
    .cmd_busy_o(cmd_busy_o),
    .cmd_done_o(cmd_done_o),
    .read_start_o(read_start_o),
    .read_addr_o(read_addr_o),
    .read_len_o(read_len_o),
    .read_size_o(read_size_o),
    .read_busy_i(read_busy_i),
    .write_start_o(write_start_o),
    .write_addr_o(write_addr_o),
    .write_len_o(write_len_o),
    .write_size_o(write_size_o),
    .write_busy_i(write_busy_i)
  );

  typedef struct {
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [7:0]    len;
  } burst_t;

  burst_t exp_q[$];
  int nchecks = 0;
  int nerr = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int rcnt = 0, wcnt = 0, force_hold = 0;
  bit pend = 0, prev_start = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected burst list from the page/cap rules, computed with plain integer arithmetic.
  function automatic void build(input logic [AW-1:0] s_in, input logic [AW-1:0] d_in, input int beats);
    logic [AW-1:0] s, d;
    int b, sr, dr;
    s = s_in & ~32'h7;
    d = d_in & ~32'h7;
    while (beats > 0) begin
      sr = (4096 - int'(s[11:0])) / BPB;
      dr = (4096 - int'(d[11:0])) / BPB;
      b = beats;
      if (b > MAXB) b = MAXB;
      if (b > sr) b = sr;
      if (b > dr) b = dr;
      exp_q.push_back('{ra: s, wa: d, len: 8'(b - 1)});
      s = s + 32'(b * BPB);
      d = d + 32'(b * BPB);
      beats = beats - b;
    end
  endfunction

  task automatic pin(input string nm, input int idx, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                     input logic [7:0] len);
    chk({nm, "_ra"}, exp_q[idx].ra, ra);
    chk({nm, "_wa"}, exp_q[idx].wa, wa);
    chk({nm, "_len"}, exp_q[idx].len, len);
  endtask

  // Checker plus Dma emulation: busy rises one cycle after start and holds a random time.
  always @(negedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      rcnt = 0; wcnt = 0; pend = 0; prev_start = 0;
      read_busy_i = 1'b0; write_busy_i = 1'b0;
    end else begin
      if (read_start_o || write_start_o) begin
        burst_t b;
        start_cnt++;
        chk("read_start", read_start_o, 1);
        chk("write_start", write_start_o, 1);
        chk("start_while_busy", read_busy_i | write_busy_i, 0);
        chk("start_back_to_back", prev_start, 0);
        chk("busy_at_issue", cmd_busy_o, 1);
        chk("read_size", read_size_o, 3);
        chk("write_size", write_size_o, 3);
        chk("burst_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("read_addr", read_addr_o, b.ra);
          chk("write_addr", write_addr_o, b.wa);
          chk("read_len", read_len_o, b.len);
          chk("write_len", write_len_o, b.len);
        end
      end
      if (cmd_done_o) begin
        done_cnt++;
        chk("busy_at_done", cmd_busy_o, 0);
        chk("bursts_left_at_done", exp_q.size(), 0);
      end
      prev_start = read_start_o || write_start_o;
      if (rcnt > 0) rcnt--;
      if (wcnt > 0) wcnt--;
      if (pend) begin
        rcnt = (force_hold > 0) ? force_hold : int'($urandom_range(1, 6));
        wcnt = (force_hold > 0) ? force_hold : int'($urandom_range(1, 6));
        pend = 0;
      end
      if (read_start_o) pend = 1;
      read_busy_i  = (rcnt > 0);
      write_busy_i = (wcnt > 0);
    end
  end

  task automatic scramble_cmd();
    cmd_src_addr_i = $urandom;
    cmd_dst_addr_i = $urandom;
    cmd_beats_i    = BW'($urandom);
  endtask

  task automatic run_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input int beats, input int restrobe_at);
    int d0, s0, n, k;
    bit got;
    build(s, d, beats);
    n  = exp_q.size();
    d0 = done_cnt;
    s0 = start_cnt;
    @(posedge m_axi_aclk); #1;
    cmd_start_i = 1'b1; cmd_src_addr_i = s; cmd_dst_addr_i = d; cmd_beats_i = BW'(beats);
    @(posedge m_axi_aclk); #1;
    cmd_start_i = 1'b0;
    scramble_cmd();
    if (beats > 0) chk("busy_after_strobe", cmd_busy_o, 1);
    k = 1;
    got = (done_cnt != d0);
    while (k < 3000 && !got) begin
      cmd_start_i = (restrobe_at > 0 && k == restrobe_at);
      @(posedge m_axi_aclk); #1;
      k++;
      got = (done_cnt != d0);
    end
    cmd_start_i = 1'b0;
    chk("cmd_completes", got, 1);
    if (beats == 0) chk("zero_beats_done_latency", k <= 2, 1);
    repeat (3) @(posedge m_axi_aclk);
    #1;
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("burst_count", start_cnt - s0, n);
    chk("bursts_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [AW-1:0] rs, rd;
    int d0;
    bit got;
    m_axi_aresetn = 1'b0;
    cmd_start_i   = 1'b0;
    cmd_src_addr_i = '0; cmd_dst_addr_i = '0; cmd_beats_i = '0;
    repeat (3) @(posedge m_axi_aclk);
    #1;
    chk("rst_busy", cmd_busy_o, 0);
    chk("rst_done", cmd_done_o, 0);
    chk("rst_rstart", read_start_o, 0);
    chk("rst_wstart", write_start_o, 0);
    chk("rst_raddr", read_addr_o, 0);
    chk("rst_waddr", write_addr_o, 0);
    chk("rst_rlen", read_len_o, 0);
    chk("rst_wlen", write_len_o, 0);
    chk("rst_rsize", read_size_o, 3);
    chk("rst_wsize", write_size_o, 3);
    m_axi_aresetn = 1'b1;

    build(32'h0, 32'h20, 16);
    chk("pin1_n", exp_q.size(), 1);
    pin("pin1", 0, 32'h0, 32'h20, 8'd15);
    exp_q.delete();
    run_cmd(32'h0, 32'h20, 16, 0);

    build(32'h0, 32'h200, 40);
    chk("pin2_n", exp_q.size(), 3);
    pin("pin2a", 0, 32'h0, 32'h200, 8'd15);
    pin("pin2b", 1, 32'h80, 32'h280, 8'd15);
    pin("pin2c", 2, 32'h100, 32'h300, 8'd7);
    exp_q.delete();
    run_cmd(32'h0, 32'h200, 40, 0);

    build(32'hFF0, 32'h2000, 4);
    chk("pin3_n", exp_q.size(), 2);
    pin("pin3a", 0, 32'hFF0, 32'h2000, 8'd1);
    pin("pin3b", 1, 32'h1000, 32'h2010, 8'd1);
    exp_q.delete();
    run_cmd(32'hFF0, 32'h2000, 4, 0);

    build(32'h0, 32'h1FF8, 4);
    chk("pin4_n", exp_q.size(), 2);
    pin("pin4a", 0, 32'h0, 32'h1FF8, 8'd0);
    pin("pin4b", 1, 32'h8, 32'h2000, 8'd2);
    exp_q.delete();
    run_cmd(32'h0, 32'h1FF8, 4, 0);

    run_cmd(32'h1234, 32'h5678, 0, 0);
    run_cmd(32'hFFFF_FFF0, 32'h0000_0400, 4, 0);
    run_cmd(32'h0, 32'h200, 40, 5);
    run_cmd(32'h0, 32'h200, 40, 9);
    force_hold = 50;
    run_cmd(32'h40, 32'h80, 32, 0);
    force_hold = 20;

    // Reset while the engines are busy: the command is dropped without a done pulse.
    build(32'h0, 32'h0, 40);
    d0 = done_cnt;
    @(posedge m_axi_aclk); #1;
    cmd_start_i = 1'b1; cmd_src_addr_i = 32'h0; cmd_dst_addr_i = 32'h0; cmd_beats_i = 16'd40;
    @(posedge m_axi_aclk); #1;
    cmd_start_i = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge m_axi_aclk); #1;
      got = read_busy_i;
    end
    chk("reset_test_reached_wait", got, 1);
    @(posedge m_axi_aclk); #1;
    m_axi_aresetn = 1'b0;
    @(posedge m_axi_aclk); #1;
    exp_q.delete();
    chk("mid_rst_busy", cmd_busy_o, 0);
    chk("mid_rst_done", cmd_done_o, 0);
    chk("mid_rst_rstart", read_start_o, 0);
    chk("mid_rst_wstart", write_start_o, 0);
    chk("mid_rst_raddr", read_addr_o, 0);
    chk("mid_rst_waddr", write_addr_o, 0);
    chk("mid_rst_len", {read_len_o, write_len_o}, 0);
    chk("mid_rst_size", {read_size_o, write_size_o}, 6'o33);
    m_axi_aresetn = 1'b1;
    force_hold = 0;
    repeat (5) @(posedge m_axi_aclk);
    #1;
    chk("no_done_after_reset", done_cnt - d0, 0);
    run_cmd(32'h100, 32'h300, 20, 0);

    for (int i = 0; i < 40; i++) begin
      rs = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) rs[11:8] = 4'hF;
      if ($urandom_range(0, 1) == 1) rd[11:8] = 4'hF;
      run_cmd(rs, rd, int'($urandom_range(0, 70)), (i % 4 == 0) ? int'($urandom_range(2, 12)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/dma_burst_sequencer.md
Name: dma_burst_sequencer

Overview:
Command-side front end that sits directly upstream of the Dma block and drives its read/write control ports. Takes one copy command (source address, destination address, total beat count) and splits it into AXI bursts. Each burst is capped at MAX_BURST beats and never crosses a 4 KB boundary on either the source or the destination. For each burst the block pulses the Dma read and write start inputs together, then waits until both engines go idle before issuing the next burst.

Parameters:
DMA_DATA_WIDTH_SRC, 64, data beat width in bits (power of 2, 8..1024); beat size SIZE_LOG2 = log2(DMA_DATA_WIDTH_SRC/8)
DMA_AXI_ADDR_WIDTH, 32, address width
MAX_BURST, 16, maximum beats per burst (1..256)
BEATS_WIDTH, 16, width of total beat count

Ports:
m_axi_aclk  in  1  clock
m_axi_aresetn  in  1  synchronous active-low reset
cmd_start_i  in  1  single-cycle command strobe
cmd_src_addr_i  in  DMA_AXI_ADDR_WIDTH  source byte address
cmd_dst_addr_i  in  DMA_AXI_ADDR_WIDTH  destination byte address
cmd_beats_i  in  BEATS_WIDTH  total beats to copy
cmd_busy_o  out  1  command in progress
cmd_done_o  out  1  one-cycle pulse when command completes
read_start_o  out  1  to Dma read_start_i
read_addr_o  out  DMA_AXI_ADDR_WIDTH  to Dma read_addr_i
read_len_o  out  8  to Dma read_len_i (beats-1)
read_size_o  out  3  to Dma read_size_i
read_busy_i  in  1  from Dma read_busy_o
write_start_o  out  1  to Dma write_start_i
write_addr_o  out  DMA_AXI_ADDR_WIDTH  to Dma write_addr_i
write_len_o  out  8  to Dma write_len_i
write_size_o  out  3  to Dma write_size_i
write_busy_i  in  1  from Dma write_busy_o

Behaviour:
- Reset (m_axi_aresetn=0 at a rising edge): state IDLE. All outputs 0 except read_size_o/write_size_o = SIZE_LOG2 (constant). Applies mid-command: the burst in flight is abandoned, no done pulse.
- Addresses are beat-aligned. Low SIZE_LOG2 address bits are forced to 0 when latched.
- States: IDLE, CALC, ISSUE, GUARD, WAIT, DONE.
- IDLE: cmd_start_i=1 latches src, dst and remaining=cmd_beats_i, and sets cmd_busy_o on the next cycle. If cmd_beats_i=0, go to DONE, otherwise go to CALC.
- CALC (1 cycle): src_room = (4096 - src[11:0]) >> SIZE_LOG2; dst_room likewise. burst = min(remaining, MAX_BURST, src_room, dst_room). Compute at width BEATS_WIDTH+1 so no intermediate truncates. burst is always >= 1.
- ISSUE (1 cycle): read_start_o = write_start_o = 1 in the same cycle; read_addr_o=src, write_addr_o=dst, read_len_o = write_len_o = burst-1. Addresses and len are registered and held stable until the next ISSUE.
- GUARD (1 cycle): busy inputs are ignored, which covers the Dma's one-cycle busy-rise latency.
- WAIT: stay while read_busy_i | write_busy_i. When both are 0: src += burst<<SIZE_LOG2, dst += burst<<SIZE_LOG2, remaining -= burst. Go to DONE if remaining=0, else CALC.
- DONE (1 cycle): cmd_done_o=1; cmd_busy_o drops the same cycle; return to IDLE.
- cmd_busy_o is 1 in CALC, ISSUE, GUARD and WAIT.
- cmd_start_i outside IDLE (including during DONE) is ignored; no queueing.
- Address wrap at 2^DMA_AXI_ADDR_WIDTH is modulo, no error.
- read/write_start_o are never high for more than one cycle. No new start is issued while either busy input is high.

Test Plan:
- 64-bit, src=0, dst=32, beats=16 -> one ISSUE: read_addr 0, write_addr 32, len 15, size 3; cmd_done_o pulses once after both busy inputs fall.
- beats=40, src=0, dst=0x200, MAX_BURST=16 -> three bursts: len 15/15/7, read_addr 0/0x80/0x100, write_addr 0x200/0x280/0x300; exactly one done pulse.
- src=0xFF0, dst=0x2000, beats=4 -> bursts of 2 beats (src 0xFF0) then 2 beats (src 0x1000, dst 0x2010); dst-side crossing (dst=0x1FF8, src=0) -> 1 beat then 3 beats.
- beats=0 -> no read/write_start_o; cmd_done_o pulses within 2 cycles of the strobe.
- cmd_start_i re-asserted mid-command with different args -> ignored; original burst sequence completes unchanged. Busy inputs held high for 50 cycles -> no second start during that time.
- Reset asserted in WAIT -> next cycle all outputs at reset values, no done pulse; a fresh command afterwards runs normally.
